pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS32 fetch stage. It generates the instruction fetch address and the instruction-memory chip enable, and it supports stall, halt, branch/jump redirect and an optional exception redirect. It sits between the instruction ROM address port and the decode/control logic, which drive the stall, branch and exception requests.

---
 rtl/pc_unit.sv | 113 +++++++++++
 tb/tb_pc_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// MIPS32 fetch-stage program counter: sequential step, stall, halt and branch redirect.
// Optional exception redirect to EXC_VECTOR when the PC_EXC_EN macro is defined.
module pc_unit #(
    parameter int unsigned             ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]       RESET_VECTOR = 32'h00000000,
    parameter logic [ADDR_W-1:0]       EXC_VECTOR   = 32'h00000020,
    parameter int unsigned             STEP         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
`ifdef PC_EXC_EN
    input  logic              exc_valid,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic [ADDR_W-1:0] link_addr,
    output logic              misalign
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] LINK_OFF = ADDR_W'(2 * STEP);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] link_q, link_d;
    logic              ce_q, ce_d;
    logic              misalign_q, misalign_d;
    logic              exc_req;

`ifdef PC_EXC_EN
    assign exc_req = exc_valid;
`else
    assign exc_req = 1'b0;
`endif

    // Next-state and next-pc selection; outputs are all derived from the
    // registered next values so nothing from the inputs reaches a port directly.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (exc_req) begin
`ifdef PC_EXC_EN
                    pc_d = EXC_VECTOR;
`endif
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (br_valid) begin
                    pc_d       = {br_target[ADDR_W-1:2], 2'b00};
                    misalign_d = |br_target[1:0];
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc_q + STEP_INC;
                end
            end
            ST_HALTED: begin
                if (exc_req) begin
`ifdef PC_EXC_EN
                    pc_d = EXC_VECTOR;
`endif
                    state_d = ST_RUN;
                end else if (!halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        ce_d   = (state_d == ST_RUN);
        link_d = pc_d + LINK_OFF;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            pc_q       <= RESET_VECTOR;
            link_q     <= RESET_VECTOR + LINK_OFF;
            ce_q       <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            link_q     <= link_d;
            ce_q       <= ce_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc        = pc_q;
    assign ce        = ce_q;
    assign link_addr = link_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset release, stall vs branch, misaligned branch,
// halt/resume, wrap-around, exception redirect (PC_EXC_EN) and async reset.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        halt;
    logic        br_valid;
    logic [31:0] br_target;
`ifdef PC_EXC_EN
    logic        exc_valid;
`endif
    logic [31:0] pc;
    logic        ce;
    logic [31:0] link_addr;
    logic        misalign;

    int n_pass  = 0;
    int n_total = 0;

    pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .halt      (halt),
        .br_valid  (br_valid),
        .br_target (br_target),
`ifdef PC_EXC_EN
        .exc_valid (exc_valid),
`endif
        .pc        (pc),
        .ce        (ce),
        .link_addr (link_addr),
        .misalign  (misalign)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are changed right after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        halt      = 1'b0;
        br_valid  = 1'b0;
        br_target = 32'h0;
`ifdef PC_EXC_EN
        exc_valid = 1'b0;
`endif
    endtask

    // Accept one aligned branch so the next scenario starts at a known pc.
    task automatic jump_to(input logic [31:0] target);
        br_valid  = 1'b1;
        br_target = target;
        tick();
        br_valid  = 1'b0;
        n_total++;
        if (pc !== target) $display("FAIL jump_to pc got=%h exp=%h", pc, target);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (ce !== 1'b0 || pc !== 32'h0 || link_addr !== 32'h8 || misalign !== 1'b0)
                $display("FAIL reset_hold cyc=%0d ce=%b pc=%h link=%h mis=%b exp ce=0 pc=0 link=8 mis=0",
                         i, ce, pc, link_addr, misalign);
            else n_pass++;
        end
        rst = 1'b1;
        tick();
        n_total++;
        if (ce !== 1'b1 || pc !== 32'h0)
            $display("FAIL reset_first_fetch ce=%b pc=%h exp ce=1 pc=0", ce, pc);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h4) $display("FAIL reset_step1 pc got=%h exp=4", pc);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h8 || link_addr !== 32'h10)
            $display("FAIL reset_step2 pc=%h link=%h exp pc=8 link=10", pc, link_addr);
        else n_pass++;
    endtask

    task automatic test_stall_branch();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h10;
        exp_pc[1] = 32'h10;
        exp_pc[2] = 32'h100;
        exp_pc[3] = 32'h104;
        jump_to(32'h10);
        br_valid  = 1'b1;
        br_target = 32'h100;
        for (int i = 0; i < 4; i++) begin
            stall = (i < 2);
            if (i == 3) br_valid = 1'b0;
            tick();
            n_total++;
            if (pc !== exp_pc[i] || ce !== 1'b1)
                $display("FAIL stall_branch step=%0d pc=%h ce=%b exp pc=%h ce=1", i, pc, ce, exp_pc[i]);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_misalign();
        br_valid  = 1'b1;
        br_target = 32'h203;
        tick();
        br_valid = 1'b0;
        n_total++;
        if (pc !== 32'h200 || misalign !== 1'b1 || link_addr !== 32'h208)
            $display("FAIL misalign_accept pc=%h mis=%b link=%h exp pc=200 mis=1 link=208",
                     pc, misalign, link_addr);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h204 || misalign !== 1'b0)
            $display("FAIL misalign_pulse pc=%h mis=%b exp pc=204 mis=0", pc, misalign);
        else n_pass++;
        // Aligned branch must not raise misalign.
        jump_to(32'h300);
        n_total++;
        if (misalign !== 1'b0) $display("FAIL misalign_aligned mis got=%b exp=0", misalign);
        else n_pass++;
    endtask

    task automatic test_halt();
        jump_to(32'h40);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // A branch request while halted must be ignored.
            br_valid  = (i == 2);
            br_target = 32'h500;
            tick();
            n_total++;
            if (ce !== 1'b0 || pc !== 32'h40)
                $display("FAIL halt_hold cyc=%0d ce=%b pc=%h exp ce=0 pc=40", i, ce, pc);
            else n_pass++;
        end
        idle_inputs();
        tick();
        n_total++;
        if (ce !== 1'b1 || pc !== 32'h40)
            $display("FAIL halt_resume ce=%b pc=%h exp ce=1 pc=40", ce, pc);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h44 || link_addr !== 32'h4c)
            $display("FAIL halt_after pc=%h link=%h exp pc=44 link=4c", pc, link_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFF8);
        n_total++;
        if (link_addr !== 32'h0) $display("FAIL wrap_link0 link got=%h exp=0", link_addr);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'hFFFF_FFFC || link_addr !== 32'h4)
            $display("FAIL wrap_top pc=%h link=%h exp pc=fffffffc link=4", pc, link_addr);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h0 || link_addr !== 32'h8)
            $display("FAIL wrap_zero pc=%h link=%h exp pc=0 link=8", pc, link_addr);
        else n_pass++;
    endtask

`ifdef PC_EXC_EN
    task automatic test_exception();
        jump_to(32'h60);
        exc_valid = 1'b1;
        stall     = 1'b1;
        halt      = 1'b1;
        br_valid  = 1'b1;
        br_target = 32'h700;
        tick();
        idle_inputs();
        n_total++;
        if (pc !== 32'h20 || ce !== 1'b1 || link_addr !== 32'h28)
            $display("FAIL exc_run pc=%h ce=%b link=%h exp pc=20 ce=1 link=28", pc, ce, link_addr);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h24) $display("FAIL exc_after pc got=%h exp=24", pc);
        else n_pass++;
        halt = 1'b1;
        tick();
        n_total++;
        if (ce !== 1'b0 || pc !== 32'h24)
            $display("FAIL exc_halt_enter ce=%b pc=%h exp ce=0 pc=24", ce, pc);
        else n_pass++;
        exc_valid = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (ce !== 1'b1 || pc !== 32'h20)
            $display("FAIL exc_from_halt ce=%b pc=%h exp ce=1 pc=20", ce, pc);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        jump_to(32'h80);
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (pc !== 32'h0 || ce !== 1'b0 || link_addr !== 32'h8 || misalign !== 1'b0)
            $display("FAIL async_reset pc=%h ce=%b link=%h mis=%b exp pc=0 ce=0 link=8 mis=0",
                     pc, ce, link_addr, misalign);
        else n_pass++;
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if (pc !== 32'h0 || ce !== 1'b1)
            $display("FAIL async_reset_restart pc=%h ce=%b exp pc=0 ce=1", pc, ce);
        else n_pass++;
        tick();
        n_total++;
        if (pc !== 32'h4) $display("FAIL async_reset_step pc got=%h exp=4", pc);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_stall_branch();
        test_misalign();
        test_halt();
        test_wrap();
`ifdef PC_EXC_EN
        test_exception();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
